// File: rtl/text_pack_ctrl_pkg.sv
// Shared definitions for the ASCII-to-position-code packer: code values,
// output word field offsets and controller states.
package text_pkg;

  localparam logic [4:0] POS_SPACE  = 5'd0;
  localparam logic [4:0] POS_A      = 5'd1;
  localparam logic [4:0] POS_COMMA  = 5'd29;
  localparam logic [4:0] POS_PERIOD = 5'd30;
  localparam logic [4:0] POS_QMARK  = 5'd31;

  localparam int SLOT0_LSB = 0;
  localparam int SLOT1_LSB = 5;
  localparam int SLOT2_LSB = 10;
  localparam int LAST_BIT  = 15;

  typedef enum logic {ACC, EMIT} state_t;

endpackage

// File: rtl/text_pack_ctrl_if.sv
// Character-in / packed-word-out handshake bundle for text_pack_ctrl.
interface text_pack_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_ascii;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] out_word;
  logic [1:0] out_nchars;

  modport master (
    output in_valid, in_ascii, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_nchars
  );

  modport slave (
    input  in_valid, in_ascii, in_last, out_ready,
    output in_ready, out_valid, out_word, out_nchars
  );
endinterface

// File: rtl/ascii_pos_enc.sv
// Combinational ASCII to 5-bit character-position code encoder; anything
// outside space, lowercase letters and , . ? is flagged invalid with code 0.
module ascii_pos_enc
  import text_pkg::*;
(
  input  logic [6:0] ascii,
  output logic [4:0] pos,
  output logic       invalid
);

  logic [6:0] letter_ofs;
  assign letter_ofs = ascii - 7'h60;

  always_comb begin
    pos     = POS_SPACE;
    invalid = 1'b0;
    if (ascii == 7'h20) begin
      pos = POS_SPACE;
    end else if (ascii >= 7'h61 && ascii <= 7'h7A) begin
      pos = letter_ofs[4:0];
    end else if (ascii == 7'h2C) begin
      pos = POS_COMMA;
    end else if (ascii == 7'h2E) begin
      pos = POS_PERIOD;
    end else if (ascii == 7'h3F) begin
      pos = POS_QMARK;
    end else begin
      invalid = 1'b1;
    end
  end

endmodule

// File: rtl/text_pack_ctrl.sv
// Packs three 5-bit character codes per 16-bit word with a last flag, and
// counts unmapped characters in a saturating counter.
module text_pack_ctrl
  import text_pkg::*;
#(
  parameter bit DROP_INVALID = 1'b0,
  parameter int ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  text_pack_ctrl_if.slave  bus,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t              state;
  logic [1:0]          idx;
  logic [LAST_BIT-1:0] pack;

  logic [4:0]          pos;
  logic                invalid;
  logic                in_fire;
  logic                out_fire;
  logic                store;
  logic                complete;
  logic [LAST_BIT-1:0] pack_nxt;
  logic [1:0]          idx_nxt;

  ascii_pos_enc u_enc (
    .ascii   (bus.in_ascii),
    .pos     (pos),
    .invalid (invalid)
  );

  // While a word is pending, a new character can only enter alongside its drain.
  assign bus.in_ready = rst_n && ((state == ACC) || bus.out_ready);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;
  assign store        = in_fire && !(DROP_INVALID && invalid);
  assign complete     = in_fire && (bus.in_last || (store && idx == 2'd2));

  always_comb begin
    pack_nxt = pack;
    idx_nxt  = idx;
    if (store) begin
      case (idx)
        2'd0:    pack_nxt[SLOT0_LSB +: 5] = pos;
        2'd1:    pack_nxt[SLOT1_LSB +: 5] = pos;
        default: pack_nxt[SLOT2_LSB +: 5] = pos;
      endcase
      idx_nxt = idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ACC;
      idx            <= 2'd0;
      pack           <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_word   <= '0;
      bus.out_nchars <= 2'd0;
      err_count      <= '0;
    end else begin
      if (complete) begin
        bus.out_word   <= {bus.in_last, pack_nxt};
        bus.out_nchars <= idx_nxt;
        bus.out_valid  <= 1'b1;
        pack           <= '0;
        idx            <= 2'd0;
        state          <= EMIT;
      end else begin
        if (in_fire) begin
          pack <= pack_nxt;
          idx  <= idx_nxt;
        end
        if (out_fire) begin
          bus.out_valid <= 1'b0;
          state         <= ACC;
        end
      end
      if (in_fire && invalid && err_count != ERR_MAX) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_text_pack_ctrl.sv
// Directed bench for text_pack_ctrl: one instance keeps unmapped characters,
// a second drops them; sel chooses which instance the stimulus targets.
module tb_text_pack_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       sel;
  logic       d_valid;
  logic [6:0] d_ascii;
  logic       d_last;
  logic       d_oready;

  text_pack_ctrl_if if0 ();
  text_pack_ctrl_if if1 ();
  logic [7:0] err0, err1;

  text_pack_ctrl #(.DROP_INVALID(1'b0), .ERR_W(8)) u_keep (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .err_count(err0)
  );
  text_pack_ctrl #(.DROP_INVALID(1'b1), .ERR_W(8)) u_drop (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .err_count(err1)
  );

  assign if0.in_valid  = d_valid && !sel;
  assign if0.in_ascii  = d_ascii;
  assign if0.in_last   = d_last;
  assign if0.out_ready = d_oready;
  assign if1.in_valid  = d_valid && sel;
  assign if1.in_ascii  = d_ascii;
  assign if1.in_last   = d_last;
  assign if1.out_ready = d_oready;

  logic        o_in_ready, o_valid;
  logic [15:0] o_word;
  logic [1:0]  o_nchars;
  logic [7:0]  o_err;
  assign o_in_ready = sel ? if1.in_ready   : if0.in_ready;
  assign o_valid    = sel ? if1.out_valid  : if0.out_valid;
  assign o_word     = sel ? if1.out_word   : if0.out_word;
  assign o_nchars   = sel ? if1.out_nchars : if0.out_nchars;
  assign o_err      = sel ? err1           : err0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one character, check it is accepted, hold for one rising edge.
  task automatic send(input logic [6:0] c, input logic last);
    d_valid = 1'b1;
    d_ascii = c;
    d_last  = last;
    #0;
    if (!o_in_ready) begin
      bad++;
      total++;
      $error("FAIL in_ready_at_send observed=0 expected=1");
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
    d_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] w, input logic [1:0] n);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_word"}, 32'(o_word), 32'(w));
    chk({tag, "_nchars"}, 32'(o_nchars), 32'(n));
  endtask

  initial begin
    sel = 1'b0; d_valid = 1'b0; d_ascii = 7'h0; d_last = 1'b0; d_oready = 1'b1;
    rst_n = 1'b0;
    idle(2);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_word", 32'(o_word), 32'd0);
    chk("rst_nchars", 32'(o_nchars), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("acc_in_ready", 32'(o_in_ready), 32'd1);

    // 'a','b','c' back to back
    send(7'h61, 1'b0); send(7'h62, 1'b0); send(7'h63, 1'b0);
    chk_word("abc", 16'h0C41, 2'd3);
    chk("abc_in_ready", 32'(o_in_ready), 32'd1);

    // 'h' enters slot 0 while the abc word drains, then 'i' closes the message
    send(7'h68, 1'b0);
    chk("drain_valid", 32'(o_valid), 32'd0);
    send(7'h69, 1'b1);
    chk_word("hi", 16'h8128, 2'd2);
    idle(1);
    chk("hi_drained", 32'(o_valid), 32'd0);
    chk("hold_word", 32'(o_word), 32'h8128);

    // Backpressure, then release together with 'd'
    d_oready = 1'b0;
    send(7'h61, 1'b0); send(7'h62, 1'b0); send(7'h63, 1'b0);
    idle(2);
    chk_word("stall", 16'h0C41, 2'd3);
    chk("stall_in_ready", 32'(o_in_ready), 32'd0);
    d_oready = 1'b1;
    send(7'h64, 1'b0);
    chk("d_drain_valid", 32'(o_valid), 32'd0);
    send(7'h65, 1'b0); send(7'h66, 1'b0);
    chk_word("def", 16'h18A4, 2'd3);
    idle(1);

    // Unmapped 'A' kept as code 0
    send(7'h41, 1'b0); send(7'h62, 1'b0); send(7'h63, 1'b0);
    chk_word("Abc_keep", 16'h0C40, 2'd3);
    chk("Abc_keep_err", 32'(o_err), 32'd1);
    idle(1);

    // Unmapped 'A' dropped
    sel = 1'b1;
    send(7'h41, 1'b0); send(7'h62, 1'b0); send(7'h63, 1'b0);
    chk("Abc_drop_valid", 32'(o_valid), 32'd0);
    chk("Abc_drop_err", 32'(o_err), 32'd1);
    send(7'h64, 1'b0);
    chk_word("bcd_drop", 16'h1062, 2'd3);
    idle(1);
    send(7'h41, 1'b1);
    chk_word("empty_last", 16'h8000, 2'd0);
    chk("empty_last_err", 32'(o_err), 32'd2);
    idle(1);
    sel = 1'b0;

    // Reset in the middle of a word
    send(7'h61, 1'b0); send(7'h62, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_err", 32'(o_err), 32'd0);
    chk("midrst_in_ready", 32'(o_in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(7'h7A, 1'b0); send(7'h2E, 1'b0); send(7'h3F, 1'b0);
    chk_word("zpq", 16'h7FDA, 2'd3);
    idle(1);

    // Error counter saturation
    for (int i = 0; i < 254; i++) send(7'h41, 1'b0);
    chk("err_254", 32'(o_err), 32'd254);
    for (int i = 0; i < 6; i++) send(7'h41, 1'b0);
    chk("err_sat", 32'(o_err), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_pack_ctrl.md
Name: text_pack_ctrl

Overview:
- Streaming controller that accepts 7-bit ASCII characters over a valid/ready handshake.
- Each character is encoded to the team's 5-bit character-position code: space=0, a–z=1–26, ','=29, '.'=30, '?'=31.
- Three codes are packed per 16-bit output word, which is emitted over a second valid/ready handshake.
- Sits between a character source (UART/keypad front end) and the word-wide message store; also counts unmapped characters.

Parameters:
- DROP_INVALID, 0: 1 = unmapped characters are discarded; 0 = unmapped characters are packed as code 0.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input character valid
- in_ready  out  1  controller can accept a character this cycle
- in_ascii  in  7  ASCII character
- in_last  in  1  character is the last of its message
- out_valid  out  1  out_word valid
- out_ready  in  1  sink accepts out_word
- out_word  out  16  [15]=last flag, [14:10]=slot2, [9:5]=slot1, [4:0]=slot0 (slot0 = first character)
- out_nchars  out  2  number of valid slots (0–3)
- err_count  out  ERR_W  saturating count of unmapped characters

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC, slot index idx=0, pack register=0.
  - out_valid=0, out_word=0, out_nchars=0, err_count=0.
  - in_ready=0 while rst_n=0.
- Encoding: combinational.
  - Mapping: 0x20→0, 0x61–0x7A→1–26, 0x2C→29, 0x2E→30, 0x3F→31.
  - Every other value (including uppercase) is unmapped: code 0, invalid flag set.
  - Codes 27 and 28 are never produced.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- State ACC:
  - in_ready=1 and out_valid=0.
  - On transfer, write the code into slot[idx] and increment idx.
  - If the stored character fills slot 2, or in_last=1: load out_word/out_nchars from the pack register including the new code, set out_valid=1, clear the pack register, idx=0, go to EMIT.
  - Latency: output word valid the cycle after the completing input transfer.
- State EMIT:
  - out_valid=1; out_word and out_nchars held stable until transfer.
  - in_ready = out_ready (combinational). A character accepted in the same cycle as the output transfer is stored in slot 0 (idx becomes 1); this sustains 3 characters per 3 cycles.
  - On output transfer: if that same-cycle character also completes a word (in_last=1), the new word is loaded immediately and the state stays EMIT. Otherwise the state goes to ACC.
- Unused slots are 0. out_word[15] = in_last of the completing character.
- Unmapped characters:
  - err_count increments by 1 per accepted unmapped character and saturates at 2^ERR_W−1.
  - DROP_INVALID=0: packed as code 0.
  - DROP_INVALID=1: not stored and idx unchanged. If it carries in_last, the word is emitted anyway. With idx=0 this gives out_nchars=0, out_word=0x8000 (empty end-of-message marker).
- A word holding 0 < idx < 3 without a last character waits indefinitely; there is no timeout.
- out_word keeps the last emitted value while out_valid=0.
- Reset mid-word or mid-EMIT discards the partial word and any pending output.

Decomposition:
- Shared package text_pkg holds:
  - code constants: POS_SPACE=0, POS_A=1, POS_COMMA=29, POS_PERIOD=30, POS_QMARK=31;
  - word field offsets (SLOT0_LSB=0, SLOT1_LSB=5, SLOT2_LSB=10, LAST_BIT=15);
  - state enum {ACC, EMIT}.
- One combinational sub-module, ascii_pos_enc (in_ascii → pos[4:0], invalid), instantiated once.

Test Plan:
- 'a','b','c' back-to-back, out_ready=1 → one word 0x0C41, nchars=3, last=0, in_ready never drops.
- 'h','i'(in_last=1) → word 0x8128, nchars=2, next word starts at slot 0.
- out_ready=0 after 'a','b','c' → out_valid stays 1, out_word stable at 0x0C41, in_ready=0. Raise out_ready together with in_valid 'd' → transfer and 'd' accepted in the same cycle; next word slot0=4.
- 'A'(0x41),'b','c': DROP_INVALID=0 → word 0x0C40, err_count=1. DROP_INVALID=1 → no word until a third valid char; err_count=1. DROP_INVALID=1 with 'A' as the only char, in_last=1 → word 0x8000, nchars=0.
- 'a','b' then rst_n low for one cycle → out_valid=0, err_count=0. Then 'z','.','?' → word 0x7FDA, nchars=3.
- 260 unmapped chars with ERR_W=8 → err_count saturates at 255 with no wrap.
